// File: rtl/dmem_port.sv
// dmem_port: data-memory access stage between the memory pipeline register and
// writeback. It runs a request/grant/response handshake on the data bus, stalls
// the pipeline while an access is outstanding, and returns aligned load data or
// an exception code for one cycle in DONE.
//
// Optional feature: define DMEM_MISALIGN_EXC_EN to reject misaligned loads and
// stores with MISALIGN_EXC instead of issuing them. Without it, the load offset
// is truncated (half uses addr[1], word uses offset 0).

module dmem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  BUS_ERR_EXC    = 8'h85,
    parameter logic [7:0]  MISALIGN_EXC   = 8'h84
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        flush,
    input  logic        bubble_in,
    input  logic        mem_re_in,
    input  logic [3:0]  mem_we_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  ld_size_in,
    input  logic        ld_signed_in,
    input  logic [7:0]  exc_in,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        stall,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic [7:0]  exc_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Saturation point of the outstanding-access counter.
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_sgn;

    logic        req_present;
    logic        start;
    logic        start_mis;
    logic        timeout;
    logic        is_store;

    // Control strobes decoded by the next-state logic.
    logic        launch;
    logic        req_drop;
    logic        done_load;
    logic        done_err;
    logic        done_mis;
    logic        clr_out;
    logic        cnt_clr;
    logic        counting;

    // Select the addressed byte/halfword and extend it to 32 bits.
    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic        ext;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0: begin
                ext = sgn & b[7];
                res = {{24{ext}}, b};
            end
            2'd1: begin
                ext = sgn & h[15];
                res = {{16{ext}}, h};
            end
            default: begin
                ext = 1'b0;
                res = rdata;
            end
        endcase
        return res;
    endfunction

`ifdef DMEM_MISALIGN_EXC_EN
    // Stores must use a naturally aligned byte, half or word lane pattern;
    // loads must be aligned to their size.
    function automatic logic misaligned(input logic [3:0] we,
                                        input logic [1:0] size,
                                        input logic [1:0] off);
        logic bad;
        if (we != 4'b0000) begin
            case (we)
                4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0011, 4'b1100, 4'b1111: bad = 1'b0;
                default:                   bad = 1'b1;
            endcase
        end else begin
            case (size)
                2'd0:    bad = 1'b0;
                2'd1:    bad = off[0];
                default: bad = (off != 2'b00);
            endcase
        end
        return bad;
    endfunction

    assign start_mis = start && misaligned(mem_we_in, ld_size_in, addr_in[1:0]);
`else
    assign start_mis = 1'b0;
`endif

    assign req_present = !bubble_in && (exc_in == 8'h00) &&
                         (mem_re_in || (mem_we_in != 4'b0000));
    assign start       = (state_q == IDLE) && !flush && req_present;
    assign timeout     = (cnt_q >= (TO_LIMIT - 8'd1));
    assign is_store    = (bus_we != 4'b0000);
    assign counting    = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);

    assign stall = rst_n && (start || (state_q == REQ) || (state_q == WAIT) ||
                             ((state_q == DRAIN) && req_present));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; flush outranks errors, errors outrank
    // grant/response.
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        req_drop  = 1'b0;
        done_load = 1'b0;
        done_err  = 1'b0;
        done_mis  = 1'b0;
        clr_out   = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    clr_out = 1'b1;
                end else if (start_mis) begin
                    state_d  = DONE;
                    done_mis = 1'b1;
                end else if (start) begin
                    state_d = REQ;
                    launch  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            REQ: begin
                if (flush) begin
                    state_d  = IDLE;
                    req_drop = 1'b1;
                    clr_out  = 1'b1;
                end else if (bus_err || timeout) begin
                    state_d  = DONE;
                    req_drop = 1'b1;
                    done_err = 1'b1;
                end else if (bus_gnt) begin
                    req_drop = 1'b1;
                    state_d  = is_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d  = DRAIN;
                    req_drop = 1'b1;
                    clr_out  = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (bus_err || timeout) begin
                    state_d  = DONE;
                    done_err = 1'b1;
                end else if (bus_rvalid) begin
                    state_d   = DONE;
                    done_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                clr_out = 1'b1;
            end
            DRAIN: begin
                if (flush) begin
                    state_d = IDLE;
                    clr_out = 1'b1;
                end else if (bus_rvalid || bus_err || timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                clr_out = 1'b1;
            end
        endcase
    end

    // Bus request registers and the latched load attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            lat_off   <= 2'b00;
            lat_size  <= 2'b00;
            lat_sgn   <= 1'b0;
        end else if (clk_en) begin
            if (launch) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_we_in;
                bus_addr  <= {addr_in[31:2], 2'b00};
                bus_wdata <= store_data_in;
                lat_off   <= addr_in[1:0];
                lat_size  <= ld_size_in;
                lat_sgn   <= ld_signed_in;
            end else if (req_drop) begin
                bus_req <= 1'b0;
            end
        end
    end

    // Outstanding-access counter: cleared on launch and on drain entry,
    // saturating so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (clk_en) begin
            if (cnt_clr) begin
                cnt_q <= 8'd0;
            end else if (counting && (cnt_q < TO_LIMIT)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Writeback-facing result registers, nonzero only while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data_out  <= 32'h0;
            load_valid_out <= 1'b0;
            exc_out        <= 8'h00;
        end else if (clk_en) begin
            if (clr_out) begin
                load_data_out  <= 32'h0;
                load_valid_out <= 1'b0;
                exc_out        <= 8'h00;
            end else if (done_load) begin
                load_data_out  <= align_load(bus_rdata, lat_off, lat_size, lat_sgn);
                load_valid_out <= 1'b1;
                exc_out        <= 8'h00;
            end else if (done_err) begin
                load_data_out  <= 32'h0;
                load_valid_out <= 1'b0;
                exc_out        <= BUS_ERR_EXC;
            end else if (done_mis) begin
                load_data_out  <= 32'h0;
                load_valid_out <= 1'b0;
                exc_out        <= MISALIGN_EXC;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// Testbench for dmem_port: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.

module tb_dmem_port;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        bubble_in;
    logic        mem_re_in;
    logic [3:0]  mem_we_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [1:0]  ld_size_in;
    logic        ld_signed_in;
    logic [7:0]  exc_in;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        stall;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic [7:0]  exc_out;

    int checks = 0;
    int errors = 0;

    dmem_port #(
        .TIMEOUT_CYCLES(TO),
        .BUS_ERR_EXC(8'h85),
        .MISALIGN_EXC(8'h84)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .bubble_in(bubble_in), .mem_re_in(mem_re_in), .mem_we_in(mem_we_in),
        .addr_in(addr_in), .store_data_in(store_data_in), .ld_size_in(ld_size_in),
        .ld_signed_in(ld_signed_in), .exc_in(exc_in),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .stall(stall), .load_data_out(load_data_out), .load_valid_out(load_valid_out),
        .exc_out(exc_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference load result: shift the addressed field down, mask, extend.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] sz, input bit sg);
        int nbits;
        int sh;
        logic [31:0] v;
        logic [31:0] mask;
        if (sz == 2'd0) begin
            nbits = 8;  sh = 8 * int'(off);
        end else if (sz == 2'd1) begin
            nbits = 16; sh = 16 * int'(off[1]);
        end else begin
            nbits = 32; sh = 0;
        end
        v = rd >> sh;
        if (nbits == 32) return v;
        mask = (32'd1 << nbits) - 32'd1;
        v = v & mask;
        if (sg && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

`ifdef DMEM_MISALIGN_EXC_EN
    function automatic bit model_mis(input bit st, input logic [3:0] we,
                                     input logic [1:0] off, input logic [1:0] sz);
        if (st) return !(we inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111});
        if (sz == 2'd1) return off[0];
        if (sz == 2'd2) return off != 2'b00;
        return 1'b0;
    endfunction
`endif

    task automatic quiet_inputs();
        clk_en = 1'b1; flush = 1'b0; bubble_in = 1'b1; mem_re_in = 1'b0;
        mem_we_in = 4'b0; addr_in = 32'h0; store_data_in = 32'h0;
        ld_size_in = 2'd0; ld_signed_in = 1'b0; exc_in = 8'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    endtask

    // One access from IDLE. g: REQ-relative cycle of grant, r: extra WAIT
    // cycles before rvalid, e: REQ-relative cycle of bus_err (large = none).
    // Phase p counts enabled cycles: 0 start, 1.. REQ/WAIT, then DONE, then IDLE.
    task automatic run_txn(input bit st, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                           input logic [31:0] rdv, input int g, input int r, input int e,
                           input bit use_en);
        int k_norm, k_fail, kc, done_p, req_last, p, k, guard;
        bit mis, failed, en, exp_req;
        logic [31:0] exp_data;
        logic [7:0]  exp_exc;
        logic        exp_v;
        logic [3:0]  we_eff;
        we_eff = st ? we : 4'b0000;
        mis = 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
        mis = model_mis(st, we_eff, addr[1:0], sz);
`endif
        k_norm   = st ? g : g + 1 + r;
        k_fail   = (e < TO - 1) ? e : TO - 1;
        failed   = (k_fail <= k_norm);
        kc       = failed ? k_fail : k_norm;
        done_p   = mis ? 1 : kc + 2;
        req_last = (g < k_fail) ? g : k_fail;
        if (mis) begin
            exp_exc = 8'h84; exp_v = 1'b0; exp_data = 32'h0;
        end else if (failed) begin
            exp_exc = 8'h85; exp_v = 1'b0; exp_data = 32'h0;
        end else if (st) begin
            exp_exc = 8'h00; exp_v = 1'b0; exp_data = 32'h0;
        end else begin
            exp_exc = 8'h00; exp_v = 1'b1; exp_data = model_load(rdv, addr[1:0], sz, sg);
        end
        p = 0;
        guard = 0;
        while (p <= done_p + 1) begin
            en = use_en ? ($urandom_range(0, 4) != 0) : 1'b1;
            clk_en = en;
            flush = 1'b0;
            exc_in = 8'h0;
            if (p == 0) begin
                bubble_in = 1'b0; mem_re_in = !st; mem_we_in = we_eff;
                addr_in = addr; store_data_in = wd; ld_size_in = sz; ld_signed_in = sg;
            end else begin
                bubble_in = 1'b1; mem_re_in = 1'($urandom_range(0, 1));
                mem_we_in = 4'($urandom_range(0, 15)); addr_in = $urandom;
                store_data_in = $urandom; ld_size_in = 2'($urandom_range(0, 2));
            end
            k = p - 1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            if (p >= 1 && p <= kc + 1 && !mis) begin
                if (k == g) bus_gnt = 1'b1;
                else if (k > g) bus_gnt = 1'($urandom_range(0, 1));
                if (!st && k == g + 1 + r) begin
                    bus_rvalid = 1'b1; bus_rdata = rdv;
                end else if (k <= g) begin
                    bus_rvalid = 1'($urandom_range(0, 1));
                end
                if (k == e) bus_err = 1'b1;
            end else if (p >= 1) begin
                bus_gnt = 1'($urandom_range(0, 1));
                bus_rvalid = 1'($urandom_range(0, 1));
                bus_err = 1'($urandom_range(0, 1));
            end
            exp_req = !mis && (p >= 1) && ((p - 1) <= req_last);
            @(negedge clk);
            check_eq("stall", {31'b0, stall}, 32'(p < done_p));
            check_eq("bus_req", {31'b0, bus_req}, 32'(exp_req));
            if (exp_req) begin
                check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
                check_eq("bus_we", {28'b0, bus_we}, {28'b0, we_eff});
                check_eq("bus_wdata", bus_wdata, wd);
            end
            if (p == done_p) begin
                check_eq("load_valid", {31'b0, load_valid_out}, {31'b0, exp_v});
                check_eq("load_data", load_data_out, exp_data);
                check_eq("exc_out", {24'b0, exc_out}, {24'b0, exp_exc});
            end else begin
                check_eq("load_valid_idle", {31'b0, load_valid_out}, 32'h0);
                check_eq("exc_out_idle", {24'b0, exc_out}, 32'h0);
            end
            @(posedge clk); #1;
            if (en) p++;
            guard++;
            if (guard > 300) begin
                check_eq("txn_bound", 32'h0, 32'h1);
                break;
            end
        end
        quiet_inputs();
    endtask

    // Flush a load in WAIT, deliver its rvalid two cycles later while a new
    // request waits; the new request is left applied for the caller.
    task automatic run_drain(input logic [31:0] new_addr, input logic [31:0] new_wd);
        quiet_inputs();
        bubble_in = 1'b0; mem_re_in = 1'b1; addr_in = 32'h4000; ld_size_in = 2'd2;
        @(negedge clk);
        check_eq("drain_start_stall", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        bubble_in = 1'b1; bus_gnt = 1'b1;
        @(negedge clk);
        check_eq("drain_req", {31'b0, bus_req}, 32'h1);
        @(posedge clk); #1;
        bus_gnt = 1'b0; flush = 1'b1;
        @(negedge clk);
        check_eq("drain_wait_stall", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b0; bubble_in = 1'b0; mem_re_in = 1'b0; mem_we_in = 4'b0011;
        addr_in = new_addr; store_data_in = new_wd;
        @(negedge clk);
        check_eq("drain1_stall", {31'b0, stall}, 32'h1);
        check_eq("drain1_req", {31'b0, bus_req}, 32'h0);
        check_eq("drain1_valid", {31'b0, load_valid_out}, 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check_eq("drain2_stall", {31'b0, stall}, 32'h1);
        check_eq("drain2_valid", {31'b0, load_valid_out}, 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
    endtask

    task automatic run_reset_mid();
        quiet_inputs();
        bubble_in = 1'b0; mem_re_in = 1'b1; addr_in = 32'h6000; ld_size_in = 2'd2;
        @(posedge clk); #1;
        bubble_in = 1'b1;
        @(negedge clk);
        check_eq("rmid_req_before", {31'b0, bus_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rmid_req_async", {31'b0, bus_req}, 32'h0);
        check_eq("rmid_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        check_eq("rmid_stall_after", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rmid_valid", {31'b0, load_valid_out}, 32'h0);
        check_eq("rmid_req_after", {31'b0, bus_req}, 32'h0);
        @(posedge clk); #1;
    endtask

    // kind 0: bubble, 1: upstream exception, 2: no read or write.
    task automatic run_no_start(input int kind);
        quiet_inputs();
        bubble_in = (kind == 0); exc_in = (kind == 1) ? 8'h22 : 8'h00;
        mem_re_in = (kind != 2); bus_gnt = 1'b1; bus_rvalid = 1'b1;
        @(negedge clk);
        check_eq("nostart_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        quiet_inputs();
        @(negedge clk);
        check_eq("nostart_req", {31'b0, bus_req}, 32'h0);
        check_eq("nostart_valid", {31'b0, load_valid_out}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet_inputs();
        rst_n = 1'b0;
        bubble_in = 1'b0; mem_re_in = 1'b1; addr_in = 32'h1234;
        @(negedge clk);
        check_eq("rst_stall", {31'b0, stall}, 32'h0);
        check_eq("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check_eq("rst_bus_we", {28'b0, bus_we}, 32'h0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_bus_wdata", bus_wdata, 32'h0);
        check_eq("rst_load_data", load_data_out, 32'h0);
        check_eq("rst_load_valid", {31'b0, load_valid_out}, 32'h0);
        check_eq("rst_exc", {24'b0, exc_out}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet_inputs();
        @(posedge clk); #1;

        run_txn(1'b0, 4'b0, 32'h1004, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0, 99, 1'b0);
        run_txn(1'b0, 4'b0, 32'h2003, 32'h0, 2'd0, 1'b1, 32'h80FF7F01, 0, 0, 99, 1'b0);
        run_txn(1'b0, 4'b0, 32'h2002, 32'h0, 2'd1, 1'b0, 32'h80FF7F01, 0, 0, 99, 1'b0);
        run_txn(1'b1, 4'b1100, 32'h2000, 32'hABCD0000, 2'd2, 1'b0, 32'h0, 2, 0, 99, 1'b0);
        run_txn(1'b0, 4'b0, 32'h0100, 32'h0, 2'd2, 1'b0, 32'h0, 99, 0, 99, 1'b0);
        run_txn(1'b0, 4'b0, 32'h0104, 32'h0, 2'd2, 1'b0, 32'h0, 0, 5, 2, 1'b0);
        run_txn(1'b0, 4'b0, 32'h3002, 32'h0, 2'd2, 1'b0, 32'h11223344, 0, 0, 99, 1'b0);
        run_drain(32'h5000, 32'h0000BEEF);
        run_txn(1'b1, 4'b0011, 32'h5000, 32'h0000BEEF, 2'd2, 1'b0, 32'h0, 1, 0, 99, 1'b0);
        run_reset_mid();
        for (int i = 0; i < 3; i++) run_no_start(i);

        for (int n = 0; n < 60; n++) begin
            bit st;
            int e;
            st = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : 99;
            run_txn(st, 4'($urandom_range(1, 15)), $urandom, $urandom,
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), e, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
